// File: rtl/trigger_detector_hyst.sv
// trigger_detector_hyst
//   Level-crossing trigger on one of NUM_CHANNELS sample streams, with
//   hysteresis arming and a sample-counted holdoff after each trigger.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   enable         run; the first enabled cycle from IDLE latches config
//   trigger_edge   0=positive, 1=negative, 2=either, 3=positive
//   trigger_source channel select (out-of-range selects channel 0)
//   trigger_value  crossing level
//   hysteresis     arming margin below/above the level
//   holdoff        accepted samples ignored after a trigger
//   input_samples  packed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_ena         samples valid this cycle
//   out_ena        in_ena delayed one cycle
//   triggered      one-cycle crossing pulse, coincident with out_ena
//   armed          high while waiting for the crossing itself
//   trigger_count  saturating fire count (only with TRIGGER_COUNT_EN)
//
// Optional feature macro: TRIGGER_COUNT_EN
module trigger_detector_hyst #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int HOLDOFF_WIDTH = 16,
    localparam int SRC_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [1:0]                       trigger_edge,
    input  logic [SRC_W-1:0]                 trigger_source,
    input  logic [DATA_WIDTH-1:0]            trigger_value,
    input  logic [DATA_WIDTH-1:0]            hysteresis,
    input  logic [HOLDOFF_WIDTH-1:0]         holdoff,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] input_samples,
    input  logic                             in_ena,
    output logic                             out_ena,
    output logic                             triggered,
    output logic                             armed
`ifdef TRIGGER_COUNT_EN
    ,
    output logic [15:0]                      trigger_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ARMING,
        ARMED_LOW,
        ARMED_HIGH,
        HOLDOFF
    } state_t;

    state_t                   state, state_next;
    logic [1:0]               edge_r;
    logic [SRC_W-1:0]         src_r;
    logic [DATA_WIDTH-1:0]    value_r, lo_r, hi_r;
    logic [HOLDOFF_WIDTH-1:0] holdoff_r, cnt, cnt_next;
    logic [DATA_WIDTH-1:0]    sample_p0;
    logic                     fire;

    function automatic logic [DATA_WIDTH-1:0] sat_sub(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        return (b > a) ? '0 : a - b;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
    endfunction

    // Arming decision for one sample; edge code 3 behaves as positive.
    function automatic state_t arm_eval(input logic [1:0]            edge_sel,
                                        input logic [DATA_WIDTH-1:0] s,
                                        input logic [DATA_WIDTH-1:0] lo,
                                        input logic [DATA_WIDTH-1:0] hi);
        state_t r;
        r = ARMING;
        case (edge_sel)
            2'd1: if (s > hi) r = ARMED_HIGH;
            2'd2: begin
                if (s < lo)      r = ARMED_LOW;
                else if (s > hi) r = ARMED_HIGH;
            end
            default: if (s < lo) r = ARMED_LOW;
        endcase
        return r;
    endfunction

    // Stage p0: channel select from the latched source
    always_comb begin
        sample_p0 = input_samples[DATA_WIDTH-1:0];
        for (int k = 1; k < NUM_CHANNELS; k++) begin
            if (src_r == SRC_W'(k)) sample_p0 = input_samples[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_next = state;
        fire       = 1'b0;
        cnt_next   = cnt;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:       state_next = ARMING;
                ARMING:     if (in_ena) state_next = arm_eval(edge_r, sample_p0, lo_r, hi_r);
                ARMED_LOW:  if (in_ena && sample_p0 >= value_r) fire = 1'b1;
                ARMED_HIGH: if (in_ena && sample_p0 <= value_r) fire = 1'b1;
                HOLDOFF: begin
                    // The sample that exhausts the count only re-enters ARMING.
                    if (in_ena) begin
                        if (cnt <= HOLDOFF_WIDTH'(1)) begin
                            cnt_next   = '0;
                            state_next = ARMING;
                        end else begin
                            cnt_next = cnt - HOLDOFF_WIDTH'(1);
                        end
                    end
                end
                default:    state_next = IDLE;
            endcase
            if (fire) begin
                // With no holdoff the firing sample is immediately judged for
                // re-arming, so an either-edge full swing fires every sample.
                if (holdoff_r == '0) begin
                    state_next = arm_eval(edge_r, sample_p0, lo_r, hi_r);
                end else begin
                    state_next = HOLDOFF;
                    cnt_next   = holdoff_r;
                end
            end
        end
    end

    // Stage p1: registered state, pulse and strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_ena   <= 1'b0;
            triggered <= 1'b0;
            armed     <= 1'b0;
            cnt       <= '0;
            edge_r    <= '0;
            src_r     <= '0;
            value_r   <= '0;
            lo_r      <= '0;
            hi_r      <= '0;
            holdoff_r <= '0;
`ifdef TRIGGER_COUNT_EN
            trigger_count <= '0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            out_ena   <= in_ena;
            triggered <= fire;
            armed     <= (state_next == ARMED_LOW) || (state_next == ARMED_HIGH);
            if (state == IDLE && enable) begin
                edge_r    <= trigger_edge;
                // Out-of-range sources collapse to channel 0 here so the
                // select path only ever sees valid channel numbers.
                src_r     <= (int'(trigger_source) < NUM_CHANNELS) ? trigger_source : '0;
                value_r   <= trigger_value;
                lo_r      <= sat_sub(trigger_value, hysteresis);
                hi_r      <= sat_add(trigger_value, hysteresis);
                holdoff_r <= holdoff;
            end
`ifdef TRIGGER_COUNT_EN
            if (state == IDLE && enable) begin
                trigger_count <= '0;
            end else if (fire && trigger_count != 16'hFFFF) begin
                trigger_count <= trigger_count + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_trigger_detector_hyst.sv
module tb_trigger_detector_hyst;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  trigger_edge = '0;
    logic [1:0]  trigger_source = '0;
    logic [7:0]  trigger_value = '0;
    logic [7:0]  hysteresis = '0;
    logic [15:0] holdoff = '0;
    logic [7:0]  ch0 = '0, ch1 = '0, ch2 = '0;
    logic [23:0] input_samples;
    logic        in_ena = 1'b0;
    logic        out_ena, triggered, armed;
    logic [15:0] trigger_count;

    assign input_samples = {ch2, ch1, ch0};

    always #5 clk = ~clk;

    trigger_detector_hyst #(
        .DATA_WIDTH(8), .NUM_CHANNELS(3), .HOLDOFF_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .trigger_edge(trigger_edge), .trigger_source(trigger_source),
        .trigger_value(trigger_value), .hysteresis(hysteresis), .holdoff(holdoff),
        .input_samples(input_samples), .in_ena(in_ena),
        .out_ena(out_ena), .triggered(triggered), .armed(armed)
`ifdef TRIGGER_COUNT_EN
        , .trigger_count(trigger_count)
`endif
    );

`ifndef TRIGGER_COUNT_EN
    assign trigger_count = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: phase 0 = looking for an arming sample,
    // 1 = waiting to rise through the level, 2 = waiting to fall through it.
    int m_run, m_phase, m_hold, m_edge, m_val, m_lo, m_hi, m_hcfg, m_src, m_cnt;
    int e_oe, e_trig, e_armed;

    task automatic model_reset();
        m_run = 0; m_phase = 0; m_hold = 0; m_cnt = 0;
        m_edge = 0; m_val = 0; m_lo = 0; m_hi = 0; m_hcfg = 0; m_src = 0;
    endtask

    function automatic int seek(input int s);
        bit up, down;
        up   = (m_edge != 1);
        down = (m_edge == 1) || (m_edge == 2);
        if (up && s < m_lo)   return 1;
        if (down && s > m_hi) return 2;
        return 0;
    endfunction

    task automatic model_step();
        int s;
        int f;
        f = 0;
        if (!enable) begin
            m_run = 0; m_phase = 0; m_hold = 0;
        end else if (m_run == 0) begin
            m_run  = 1;
            m_edge = int'(trigger_edge);
            m_val  = int'(trigger_value);
            m_lo   = m_val - int'(hysteresis);
            if (m_lo < 0) m_lo = 0;
            m_hi   = m_val + int'(hysteresis);
            if (m_hi > 255) m_hi = 255;
            m_hcfg = int'(holdoff);
            m_src  = int'(trigger_source);
            m_phase = 0; m_hold = 0; m_cnt = 0;
        end else if (in_ena) begin
            s = (m_src == 1) ? int'(ch1) : (m_src == 2) ? int'(ch2) : int'(ch0);
            if (m_hold > 0) begin
                m_hold--;
            end else if (m_phase == 0) begin
                m_phase = seek(s);
            end else if ((m_phase == 1 && s >= m_val) || (m_phase == 2 && s <= m_val)) begin
                f = 1;
                if (m_cnt < 65535) m_cnt++;
                if (m_hcfg > 0) begin
                    m_hold  = m_hcfg;
                    m_phase = 0;
                end else begin
                    m_phase = seek(s);
                end
            end
        end
        e_oe    = int'(in_ena);
        e_trig  = f;
        e_armed = (m_run == 1 && m_hold == 0 && m_phase != 0) ? 1 : 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_check(input string name);
        step();
        chk({name, "_out_ena"}, int'(out_ena), e_oe);
        chk({name, "_triggered"}, int'(triggered), e_trig);
        chk({name, "_armed"}, int'(armed), e_armed);
`ifdef TRIGGER_COUNT_EN
        chk({name, "_count"}, int'(trigger_count), m_cnt);
`endif
    endtask

    task automatic set_cfg(input int edg, input int val, input int hys, input int ho, input int src);
        trigger_edge   = 2'(edg);
        trigger_value  = 8'(val);
        hysteresis     = 8'(hys);
        holdoff        = 16'(ho);
        trigger_source = 2'(src);
    endtask

    task automatic restart(input string name);
        enable = 1'b0; in_ena = 1'b0;
        step_check({name, "_off"});
        enable = 1'b1;
        step_check({name, "_latch"});
    endtask

    typedef struct {
        logic       ie;
        logic [7:0] c0;
        logic [7:0] c1;
        logic       et;
        logic       ea;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int ntr, tat, f1, f2, rs;

        tbl[0] = '{1'b1, 8'd200, 8'd0,   1'b0, 1'b1};
        tbl[1] = '{1'b1, 8'd0,   8'd255, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 8'd255, 8'd0,   1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'd0,   8'd255, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 8'd9,   8'd0,   1'b0, 1'b1};
        tbl[5] = '{1'b1, 8'd0,   8'd128, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 8'd255, 8'd128, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 8'd0,   8'd127, 1'b0, 1'b1};

        // Reset state
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_out_ena", int'(out_ena), 0);
        chk("rst_triggered", int'(triggered), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_count", int'(trigger_count), 0);
        reset = 1'b0;

        // Positive ramp through the level
        set_cfg(0, 128, 10, 0, 0);
        restart("t1");
        ntr = 0; tat = -1;
        for (int v = 100; v <= 140; v++) begin
            ch0 = 8'(v); in_ena = 1'b1;
            step_check("t1");
            if (v == 100) chk("t1_armed_after_100", int'(armed), 1);
            if (triggered) begin ntr++; tat = v; end
        end
        chk("t1_ntrig", ntr, 1);
        chk("t1_trig_sample", tat, 128);

        // Oscillation that never drops below the arm threshold
        restart("t2");
        ntr = 0;
        for (int i = 0; i < 10; i++) begin
            ch0 = (i % 2 == 0) ? 8'd125 : 8'd130; in_ena = 1'b1;
            step_check("t2");
            if (triggered) ntr++;
        end
        chk("t2_ntrig", ntr, 0);

        // Negative edge with holdoff 3
        set_cfg(1, 50, 5, 3, 0);
        restart("t3");
        f1 = -1; f2 = -1;
        for (int i = 0; i < 12; i++) begin
            ch0 = (i % 2 == 0) ? 8'd60 : 8'd40; in_ena = 1'b1;
            step_check("t3");
            if (triggered) begin
                if (f1 < 0) f1 = i; else if (f2 < 0) f2 = i;
            end
        end
        chk("t3_first_fire", f1, 1);
        chk("t3_second_fire", f2, 7);

        // Either edge on channel 1, hyst 0, holdoff 0
        set_cfg(2, 128, 0, 0, 1);
        restart("t4");
        for (int i = 0; i < 8; i++) begin
            in_ena = tbl[i].ie; ch0 = tbl[i].c0; ch1 = tbl[i].c1;
            step();
            chk($sformatf("t4_row%0d_out_ena", i), int'(out_ena), int'(tbl[i].ie));
            chk($sformatf("t4_row%0d_triggered", i), int'(triggered), int'(tbl[i].et));
            chk($sformatf("t4_row%0d_armed", i), int'(armed), int'(tbl[i].ea));
        end

        // Enable drops on the crossing sample, then reconfigure
        set_cfg(0, 128, 10, 0, 0);
        restart("t5");
        ch0 = 8'd100; in_ena = 1'b1;
        step_check("t5_arm");
        chk("t5_armed", int'(armed), 1);
        ch0 = 8'd200; enable = 1'b0;
        step_check("t5_drop");
        chk("t5_drop_trig", int'(triggered), 0);
        chk("t5_drop_armed", int'(armed), 0);
        set_cfg(1, 50, 5, 0, 0);
        enable = 1'b1; in_ena = 1'b0;
        step_check("t5_relatch");
        ch0 = 8'd60; in_ena = 1'b1;
        step_check("t5_rearm");
        ch0 = 8'd40;
        step_check("t5_fire");
        chk("t5_new_cfg_fire", int'(triggered), 1);

        // Boundary levels that can never fire
        set_cfg(0, 0, 7, 0, 0);
        restart("b0");
        ntr = 0;
        for (int i = 0; i < 30; i++) begin
            ch0 = 8'($urandom_range(255)); in_ena = 1'b1;
            step_check("b0");
            if (triggered) ntr++;
        end
        chk("b0_never_fires", ntr, 0);
        set_cfg(1, 255, 7, 0, 0);
        restart("b1");
        ntr = 0;
        for (int i = 0; i < 30; i++) begin
            ch0 = 8'($urandom_range(255)); in_ena = 1'b1;
            step_check("b1");
            if (triggered) ntr++;
        end
        chk("b1_never_fires", ntr, 0);

        // Reset while a pulse is out and the holdoff is running
        set_cfg(1, 50, 5, 5, 0);
        restart("t6");
        ch0 = 8'd60; in_ena = 1'b1;
        step_check("t6_arm");
        ch0 = 8'd40;
        step_check("t6_fire");
        chk("t6_pulse_before_reset", int'(triggered), 1);
        in_ena = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_out_ena", int'(out_ena), 0);
        chk("t6_rst_triggered", int'(triggered), 0);
        chk("t6_rst_armed", int'(armed), 0);
        chk("t6_rst_count", int'(trigger_count), 0);
        in_ena = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_held_out_ena", int'(out_ena), 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_ena = (i % 3 != 1);
            step_check("t6_post");
        end

        // Randomized configurations against the model
        for (int c = 0; c < 10; c++) begin
            set_cfg($urandom_range(3), $urandom_range(255), $urandom_range(40),
                    $urandom_range(4), $urandom_range(3));
            restart("rnd");
            for (int i = 0; i < 80; i++) begin
                rs = $urandom_range(3);
                ch0 = (rs == 0) ? 8'd0 : (rs == 1) ? 8'd255 : 8'($urandom_range(255));
                ch1 = 8'($urandom_range(255));
                ch2 = 8'($urandom_range(255));
                in_ena = ($urandom_range(3) != 0);
                enable = ($urandom_range(49) != 0);
                step_check("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trigger_detector_hyst.md
Name: trigger_detector_hyst

Overview:
- Parametrised successor to the single-channel 8-bit crossing detector. Selects one of NUM_CHANNELS sample streams.
- Detects positive, negative or either-edge crossings of a programmable level, with hysteresis for noise rejection and a sample-counted holdoff after each trigger.
- Sits between the ADC sample buffers and the acquisition controller. Emits a one-cycle `triggered` pulse aligned with the delayed sample strobe.

Parameters:
DATA_WIDTH, 8, sample/level/hysteresis width in bits (unsigned)
NUM_CHANNELS, 2, number of selectable trigger sources (>=1)
HOLDOFF_WIDTH, 16, width of holdoff sample counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
enable  input  1  detector run; rising edge latches configuration
trigger_edge  input  2  0=positive, 1=negative, 2=either, 3=reserved (treated as positive)
trigger_source  input  max(1,$clog2(NUM_CHANNELS))  channel select
trigger_value  input  DATA_WIDTH  crossing level
hysteresis  input  DATA_WIDTH  arming margin below/above level
holdoff  input  HOLDOFF_WIDTH  accepted samples to ignore after a trigger
input_samples  input  NUM_CHANNELS*DATA_WIDTH  packed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
in_ena  input  1  samples valid this cycle
out_ena  output  1  in_ena delayed one cycle
triggered  output  1  one-cycle crossing pulse, coincident with out_ena
armed  output  1  high while in ARMED_LOW or ARMED_HIGH

Behaviour:
- Reset: state=IDLE; out_ena=0, triggered=0, armed=0; holdoff counter=0; latched config cleared.
- Configuration latch:
  - In IDLE with enable=1, latch edge, source, value, hysteresis, holdoff; go to ARMING next cycle.
  - Config inputs are ignored while enabled. Reconfiguration requires dropping enable.
- Sample evaluation:
  - Only on cycles with in_ena=1; all states hold otherwise.
  - s = selected channel (latched source). Source >= NUM_CHANNELS selects channel 0.
- Arm thresholds, computed once at latch time and saturating:
  - lo = value - hyst, floored at 0.
  - hi = value + hyst, capped at 2^DATA_WIDTH-1.
- States:
  - IDLE: armed=0, no triggers.
  - ARMING:
    - positive: s < lo -> ARMED_LOW.
    - negative: s > hi -> ARMED_HIGH.
    - either: s < lo -> ARMED_LOW, else s > hi -> ARMED_HIGH.
    - With hyst=0 and s == value, stay in ARMING.
  - ARMED_LOW: s >= value -> fire, go to HOLDOFF, or to ARMING when holdoff==0.
  - ARMED_HIGH: s <= value -> fire, same next-state rule.
  - HOLDOFF:
    - Counter loaded with holdoff on fire; decrements per accepted sample.
    - On the sample that reaches 0, go to ARMING. That sample is not evaluated for arming.
- Fire and latency:
  - Fire sets triggered=1 on the cycle after the crossing sample, i.e. one-sample delay, with out_ena=1 on that same cycle.
  - triggered is never high for more than one cycle.
- out_ena: registered in_ena in every state while not in reset, including IDLE.
- enable deassert: from any state, next cycle is IDLE and armed=0. A crossing on the same cycle enable drops does not fire.
- Boundaries:
  - value=0 with positive edge: lo=0, never arms, never fires.
  - value=max with negative edge: likewise never fires.
  - Back-to-back triggers are possible only with holdoff=0 and either-edge, when a sample swings fully across both thresholds.
- Reset mid-operation: immediate return to reset values; any pending pulse is lost.

Optional Feature:
TRIGGER_COUNT_EN:
- When defined, adds output `trigger_count [15:0]`.
  - Increments on each fire and saturates at 16'hFFFF.
  - Clears on reset and on the enable rising-edge latch.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
1. DATA_WIDTH=8, positive, value=128, hyst=10, holdoff=0, ch0 ramps 100->140 step 1 with in_ena every cycle -> armed after sample 100 (<118); triggered once, the cycle after sample 128.
2. Same config, ch0 oscillates 125,130,125,130 -> no trigger, because the signal never falls below 118.
3. Negative, value=50, hyst=5, holdoff=3, square wave 60/40 per sample -> first fire after first 40; next 3 accepted samples ignored; re-arm on 60; fires again on the following 40.
4. Either-edge, value=128, hyst=0, holdoff=0, samples 0,255,0,255 on ch1, source=1 -> triggered on each transition after the first sample. Ch0 activity has no effect.
5. Armed on ARMED_LOW, then enable drops on the same cycle as a crossing sample -> no triggered pulse; state IDLE; armed=0. Change config, re-enable -> new config in effect.
6. Assert reset while in HOLDOFF with in_ena toggling -> all outputs 0 immediately; after release, out_ena follows in_ena one cycle late. With TRIGGER_COUNT_EN, count reads 0.
